seven_seg_scan: RTL
===================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter FREQ, default 250: dwell count; each digit is driven for FREQ+1 cycles per visit.
REQ-002 Parameter CBITS, default 8: counter width; FREQ SHALL be at most 2^CBITS-1.
REQ-003 Parameter BLANK, default 2: blanking cycles between digits; BLANK SHALL be between 1 and FREQ.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 wr_valid  in  1  new frame data offered.
REQ-007 wr_data  in  28  segment patterns; [6:0] = digit 0 … [27:21] = digit 3.
REQ-008 wr_ready  out  1  block can accept wr_data.
REQ-009 digit_en  in  4  per-digit enable; bit i enables digit i.
REQ-010 segment  out  7  segment bus shared by all digits.
REQ-011 digit_sel  out  4  one-hot digit strobe, active high.
REQ-012 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-013 State machine has three states: OFF, SCAN and BLK; segment, digit_sel and frame_done SHALL be registered and update on the same edge as the state.
REQ-014 OFF: segment=0, digit_sel=0; when digit_en!=0, next state is SCAN at idx = lowest enabled digit with cnt=0.
REQ-015 SCAN: segment=active[idx], digit_sel=1<<idx; cnt increments each cycle; when cnt==FREQ, next state is BLK with cnt=0.
REQ-016 BLK: segment=0, digit_sel=0; cnt increments; when cnt==BLANK-1, advance (REQ-017) and enter SCAN with cnt=0.
REQ-017 Advance: new idx = next enabled digit after idx in ring order 0→1→2→3→0, using digit_en sampled on the advance cycle; with a single enabled digit, new idx = idx.
REQ-018 Frame boundary: any advance where new idx <= old idx, or any OFF→SCAN transition.
REQ-019 frame_done SHALL be 1 for exactly the first SCAN cycle after a frame boundary, and 0 otherwise.
REQ-020 digit_en==0 sampled in SCAN or BLK: next state is OFF, cnt=0; any partial dwell is abandoned.
REQ-021 Disabling the current digit mid-dwell while other digits remain enabled does not stop the current dwell; that digit is skipped from the next advance onward.
REQ-022 Handshake: wr_ready = ~pending; on wr_valid && wr_ready, wr_data is captured into the shadow register and pending is set.
REQ-023 wr_data is ignored while wr_ready=0; no overwrite of the shadow register is possible.
REQ-024 Transfer shadow→active:
  - happens when pending=1 at a frame boundary, or on any cycle in OFF;
  - clears pending on the same edge;
  - the new data is visible on the first SCAN cycle of the new frame.
REQ-025 A transfer and a new accept SHALL never occur in the same cycle, because wr_ready=0 while pending=1.
REQ-026 The active buffer never changes mid-frame, so no digit within one frame shows mixed old/new data.
REQ-027 cnt is CBITS wide and never wraps, because its maximum value is FREQ.

Reset
REQ-028 rst=0 at a clock edge forces:
  - state=OFF, idx=0, cnt=0;
  - active=0, shadow=0, pending=0;
  - segment=0, digit_sel=0, frame_done=0, wr_ready=1.
REQ-029 Reset SHALL take priority over every other event, including a handshake or transfer in the same cycle.
REQ-030 Reset applied mid-dwell or mid-blank SHALL leave no residual strobe on the following cycle.

Verification (FREQ=3, BLANK=1)
REQ-031 Reset; write wr_data=28'h0C8_4A21 while in OFF; digit_en=4'hF -> segment shows 7'h21, 7'h14, 7'h21, 7'h06 on digit_sel 0001, 0010, 0100, 1000, each for 4 cycles, with 1 blank cycle (digit_sel=0) between digits; frame_done pulses every 20 cycles.
REQ-032 digit_en=4'b1010 -> digit_sel alternates 0010/1000 (4 cycles each, 1 blank between); frame_done pulses on every 0010 entry (period 10).
REQ-033 Two writes back-to-back mid-frame -> first is accepted and wr_ready drops; second is held off until the frame boundary, and display data changes only at the first SCAN cycle of the next frame.
REQ-034 digit_en goes 4'hF→0 during a dwell -> next cycle segment=0, digit_sel=0; re-enabling 4'b0100 -> SCAN at idx 2 with frame_done=1.
REQ-035 rst=0 asserted during SCAN with pending=1 -> next cycle all outputs 0, wr_ready=1, and the old shadow data never displays.
REQ-036 digit_en=4'b0001 -> digit_sel 0001 for 4 cycles, 1 blank cycle, repeating; frame_done pulses each visit (period 5).

Source files
------------

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed four-digit seven-segment scanner
//
// Scans up to four digits over a shared segment bus. Each enabled digit is
// strobed for FREQ+1 cycles, followed by BLANK dark cycles before the next
// enabled digit. Frame data is written through a one-entry shadow register
// and copied to the displayed buffer only at frame boundaries (or while idle),
// so a frame never mixes old and new patterns.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous reset, active low
//   wr_valid   new frame data offered
//   wr_data    28-bit frame, [6:0] = digit 0 ... [27:21] = digit 3
//   wr_ready   shadow register is free to accept wr_data
//   digit_en   per-digit enable, bit i enables digit i
//   segment    registered segment pattern of the strobed digit
//   digit_sel  registered one-hot digit strobe, active high
//   frame_done registered one-cycle pulse on the first cycle of each frame

module seven_seg_scan #(
  parameter int FREQ  = 250,
  parameter int CBITS = 8,
  parameter int BLANK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [27:0] wr_data,
  output logic        wr_ready,
  input  logic [3:0]  digit_en,
  output logic [6:0]  segment,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  typedef enum logic [1:0] {OFF, SCAN, BLK} state_t;

  localparam logic [CBITS-1:0] DWELL_LAST = CBITS'(FREQ);
  localparam logic [CBITS-1:0] BLANK_LAST = CBITS'(BLANK - 1);
  localparam logic [CBITS-1:0] CNT_ONE    = CBITS'(1);

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [27:0]      active, shadow, disp;
  logic             pending;
  logic             boundary, transfer, accept;
  logic [6:0]       segment_n;
  logic [3:0]       digit_sel_n;

  // Lowest enabled digit; only used when en is non-zero.
  function automatic logic [1:0] lowest_en(input logic [3:0] en);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (en[k]) r = 2'(k);
    end
    return r;
  endfunction

  // Next enabled digit after cur in ring order; k=4 wraps back to cur so a
  // lone enabled digit keeps being selected.
  function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] cand;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = cur + 2'(k);
      if (!found && en[cand]) begin
        r     = cand;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] pick(input logic [27:0] data, input logic [1:0] i);
    logic [6:0] r;
    case (i)
      2'd0:    r = data[6:0];
      2'd1:    r = data[13:7];
      2'd2:    r = data[20:14];
      default: r = data[27:21];
    endcase
    return r;
  endfunction

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    boundary    = 1'b0;
    segment_n   = 7'd0;
    digit_sel_n = 4'd0;

    case (state)
      OFF: begin
        if (digit_en != 4'd0) begin
          state_n  = SCAN;
          idx_n    = lowest_en(digit_en);
          cnt_n    = '0;
          boundary = 1'b1;
        end
      end
      SCAN: begin
        if (digit_en == 4'd0) begin
          state_n = OFF;
          cnt_n   = '0;
        end else if (cnt == DWELL_LAST) begin
          state_n = BLK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      BLK: begin
        if (digit_en == 4'd0) begin
          state_n = OFF;
          cnt_n   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n  = SCAN;
          idx_n    = next_en(idx, digit_en);
          cnt_n    = '0;
          boundary = (idx_n <= idx);
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = OFF;
        cnt_n   = '0;
      end
    endcase

    transfer = pending && (boundary || state == OFF);
    accept   = wr_valid && !pending;
    // Outputs are registered, so look ahead through a same-edge transfer.
    disp     = transfer ? shadow : active;

    if (state_n == SCAN) begin
      segment_n   = pick(disp, idx_n);
      digit_sel_n = 4'b0001 << idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= OFF;
      idx        <= 2'd0;
      cnt        <= '0;
      active     <= 28'd0;
      shadow     <= 28'd0;
      pending    <= 1'b0;
      segment    <= 7'd0;
      digit_sel  <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      segment    <= segment_n;
      digit_sel  <= digit_sel_n;
      frame_done <= boundary;
      // transfer needs pending=1 and accept needs pending=0: never both.
      if (transfer) begin
        active  <= shadow;
        pending <= 1'b0;
      end else if (accept) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end
    end
  end

  assign wr_ready = ~pending;

endmodule
